memory_bus_arbiter: RTL and testbench

- Shares one single-port memory between the core's instruction-fetch bus and data bus.
- Used where both buses connect to one unified RAM/ROM rather than separate memories.
- Data requests win by default, since a data access stalls the whole pipeline. A starvation counter guarantees fetch progress.
- Sits between the Grande_Risco5 core bus ports and the memory/peripheral interconnect.

---
 rtl/bus_pkg.sv | 45 ++++
 rtl/bus_timeout_counter.sv | 43 ++++
 rtl/memory_bus_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter and its helpers:
// FSM state encoding, bus owner encoding, default widths and a counter-width helper.
package bus_pkg;

  localparam int unsigned BUS_ADDR_WIDTH     = 32;
  localparam int unsigned BUS_DATA_WIDTH     = 32;
  localparam int unsigned BUS_MAX_WAIT       = 8;
  localparam int unsigned BUS_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } bus_state_e;

  // Which requester currently owns the memory, for debug views of the arbiter.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_D    = 2'd2
  } bus_owner_e;

  // Map an FSM state to the requester that owns the bus in that state.
  function automatic bus_owner_e state_owner(input bus_state_e st);
    bus_owner_e own;
    case (st)
      BUSY_IF: own = OWNER_IF;
      BUSY_D:  own = OWNER_D;
      default: own = OWNER_NONE;
    endcase
    return own;
  endfunction

  // Number of bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    if (max_val < 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(max_val + 32'd1);
    end
    return w;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Loadable down-counter with enable, clear and an expired flag.
// Load a cycle budget minus one; expired is high once the count has reached zero.
module bus_timeout_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear beats load, load beats decrement, and the count stops at zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {WIDTH{1'b0}};
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {WIDTH{1'b0}})) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbiter sharing one single-port memory between the instruction-fetch bus and
// the data bus. Data wins by default; a wait counter forces a starved fetch through,
// and a timeout aborts transactions the memory never completes.
module memory_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = BUS_DATA_WIDTH,
  parameter int unsigned MAX_WAIT       = BUS_MAX_WAIT,
  parameter int unsigned TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_rsp,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_rsp,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rsp,
  output logic                  bus_error
);

  localparam int unsigned WW = cnt_width(MAX_WAIT);
  localparam int unsigned TW = cnt_width((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
  localparam logic [WW-1:0] WAIT_LIMIT   = WW'(MAX_WAIT);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
  localparam bit            STARVE_EN    = (MAX_WAIT != 32'd0);
  localparam bit            TIMEOUT_EN   = (TIMEOUT_CYCLES != 32'd0);

  bus_state_e            state_q,     state_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_rsp_q,    if_rsp_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic                  d_rsp_q,     d_rsp_d;
  logic [DATA_WIDTH-1:0] d_rdata_q,   d_rdata_d;
  logic                  bus_error_q, bus_error_d;
  logic [WW-1:0]         wait_cnt_q,  wait_cnt_d;

  logic d_req;
  logic starve;
  logic grant_d;
  logic grant_if;
  logic busy;
  logic to_expired;
  logic timeout_hit;
  logic to_load;
  logic to_en;
  logic to_clr;

  // Arbitration: data wins unless the fetch side has waited its allowance.
  assign d_req       = d_read | d_write;
  assign starve      = STARVE_EN && if_req && (wait_cnt_q >= WAIT_LIMIT);
  assign grant_d     = (state_q == IDLE) && d_req && !starve;
  assign grant_if    = (state_q == IDLE) && !grant_d && if_req;
  assign busy        = (state_q == BUSY_IF) || (state_q == BUSY_D);

  // The timeout counter is armed at every grant and ticks while waiting for mem_rsp;
  // a response in the expiring cycle still counts as a normal completion.
  assign to_load     = grant_d || grant_if;
  assign to_en       = busy && !mem_rsp;
  assign timeout_hit = TIMEOUT_EN && busy && to_expired && !mem_rsp;
  assign to_clr      = busy && (mem_rsp || timeout_hit);

  bus_timeout_counter #(
    .WIDTH (TW)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clr      (to_clr),
    .load     (to_load),
    .load_val (TIMEOUT_LOAD),
    .en       (to_en),
    .expired  (to_expired)
  );

  // Fetch starvation counter: counts cycles a fetch is held off by data traffic.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req) begin
      wait_cnt_d = {WW{1'b0}};
    end else if (grant_if) begin
      wait_cnt_d = {WW{1'b0}};
    end else if (grant_d || (state_q == BUSY_D)) begin
      if (wait_cnt_q < WAIT_LIMIT) begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // FSM next state and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rsp_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rsp_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    bus_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = BUSY_D;
          mem_addr_d = d_addr;
          if (d_write) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b1;
            mem_wdata_d = d_wdata;
          end else begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
          end
        end else if (grant_if) begin
          state_d     = BUSY_IF;
          mem_addr_d  = if_addr;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
        end else begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      BUSY_IF: begin
        if (mem_rsp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if_rsp_d    = 1'b1;
          if_rdata_d  = mem_rdata;
        end else if (timeout_hit) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if_rsp_d    = 1'b1;
          if_rdata_d  = {DATA_WIDTH{1'b0}};
          bus_error_d = 1'b1;
        end else begin
          state_d     = BUSY_IF;
        end
      end
      BUSY_D: begin
        if (mem_rsp) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_rsp_d     = 1'b1;
          if (mem_read_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else if (timeout_hit) begin
          state_d     = IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          d_rsp_d     = 1'b1;
          d_rdata_d   = {DATA_WIDTH{1'b0}};
          bus_error_d = 1'b1;
        end else begin
          state_d     = BUSY_D;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      if_rsp_q    <= 1'b0;
      if_rdata_q  <= {DATA_WIDTH{1'b0}};
      d_rsp_q     <= 1'b0;
      d_rdata_q   <= {DATA_WIDTH{1'b0}};
      bus_error_q <= 1'b0;
      wait_cnt_q  <= {WW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rsp_q    <= if_rsp_d;
      if_rdata_q  <= if_rdata_d;
      d_rsp_q     <= d_rsp_d;
      d_rdata_q   <= d_rdata_d;
      bus_error_q <= bus_error_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rsp    = if_rsp_q;
  assign if_rdata  = if_rdata_q;
  assign d_rsp     = d_rsp_q;
  assign d_rdata   = d_rdata_q;
  assign bus_error = bus_error_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_memory_bus_arbiter;

  localparam int MW = 3;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_rsp;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rsp;
  logic [31:0] d_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rsp;
  logic        bus_error;

  always #5 clk = ~clk;

  memory_bus_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MAX_WAIT       (MW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rsp    (if_rsp),
    .if_rdata  (if_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rsp     (d_rsp),
    .d_rdata   (d_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rsp   (mem_rsp),
    .bus_error (bus_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Memory behaviour: 0 = random response, 1 = respond after mem_delay stall cycles, 2 = never.
  int          mem_mode;
  int          mem_delay;
  bit          mem_fixed;
  logic [31:0] mem_fixed_val;

  // Model: who owns the bus (0 none, 1 fetch, 2 data), the granted command,
  // cycles spent busy, fetch losses so far, and expected response outputs.
  int          m_own;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  bit          m_addr_chk;
  int          m_bc;
  int          m_fw;
  bit          m_if_rsp;
  bit          m_d_rsp;
  bit          m_err;
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory side stimulus for the current cycle.
  task automatic drive_mem();
    bit busy;
    busy = (m_own != 0);
    case (mem_mode)
      0: mem_rsp = busy ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      1: mem_rsp = busy && (m_bc == mem_delay);
      default: mem_rsp = 1'b0;
    endcase
    mem_rdata = mem_fixed ? mem_fixed_val : $urandom;
  endtask

  // What the arbiter must do at the coming clock edge, given the current inputs.
  task automatic model_edge();
    bit dreq;
    bit starve;
    if (reset) begin
      m_own = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_addr_chk = 1;
      m_bc = 0; m_fw = 0; m_if_rsp = 0; m_d_rsp = 0; m_err = 0;
      m_if_rdata = 0; m_d_rdata = 0;
    end else begin
      m_if_rsp = 0; m_d_rsp = 0; m_err = 0;
      if (m_own == 0) begin
        dreq   = d_read | d_write;
        starve = if_req && (MW != 0) && (m_fw >= MW);
        m_bc   = 0;
        if (dreq && !starve) begin
          m_own = 2; m_wr = d_write; m_addr = d_addr; m_addr_chk = 0;
          if (d_write) m_wdata = d_wdata;
          m_fw = if_req ? ((m_fw < MW) ? m_fw + 1 : m_fw) : 0;
        end else if (if_req) begin
          m_own = 1; m_wr = 0; m_addr = if_addr; m_addr_chk = 0; m_fw = 0;
        end else begin
          m_fw = 0;
        end
      end else begin
        if (!if_req) m_fw = 0;
        else if (m_own == 2 && m_fw < MW) m_fw = m_fw + 1;
        if (mem_rsp) begin
          if (m_own == 1) begin m_if_rsp = 1; m_if_rdata = mem_rdata; end
          else begin m_d_rsp = 1; if (!m_wr) m_d_rdata = mem_rdata; end
          m_own = 0;
        end else if (TO != 0 && m_bc == TO - 1) begin
          if (m_own == 1) begin m_if_rsp = 1; m_if_rdata = 0; end
          else begin m_d_rsp = 1; m_d_rdata = 0; end
          m_err = 1; m_own = 0;
        end else begin
          m_bc++;
        end
      end
    end
  endtask

  task automatic compare();
    bit busy;
    busy = (m_own != 0);
    check_eq("mem_read",  32'(mem_read),  32'(busy && !m_wr));
    check_eq("mem_write", 32'(mem_write), 32'(busy && m_wr));
    check_eq("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    if (busy || m_addr_chk) check_eq("mem_addr", mem_addr, m_addr);
    if ((busy && m_wr) || m_addr_chk) check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("if_rsp",    32'(if_rsp),    32'(m_if_rsp));
    check_eq("d_rsp",     32'(d_rsp),     32'(m_d_rsp));
    check_eq("bus_error", 32'(bus_error), 32'(m_err));
    check_eq("if_rdata",  if_rdata, m_if_rdata);
    check_eq("d_rdata",   d_rdata,  m_d_rdata);
  endtask

  // One clock: drive memory, advance the model, then check outputs mid-cycle.
  task automatic tick();
    drive_mem();
    model_edge();
    @(negedge clk);
    compare();
  endtask

  // Random requesters that hold their level until the matching response.
  task automatic auto_requesters();
    int op;
    if (if_req) begin
      if (m_if_rsp) begin
        if_req = ($urandom_range(0, 1) == 0); if_addr = $urandom;
      end else if (m_own != 1 && $urandom_range(0, 15) == 0) begin
        if_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = $urandom;
    end
    if (d_read | d_write) begin
      if (m_d_rsp || (m_own != 2 && $urandom_range(0, 15) == 0)) begin
        d_read = 1'b0; d_write = 1'b0;
      end
    end else if ($urandom_range(0, 1) == 0) begin
      op = $urandom_range(0, 3);
      d_read  = (op == 0) || (op == 3);
      d_write = (op != 0);
      d_addr  = $urandom; d_wdata = $urandom;
    end
  endtask

  initial begin
    int          first_rd, first_rsp, cnt_a, cnt_b, n_cmd, drsp_cyc, cmd2_cyc;
    bit          prev_cmd, got_if;
    logic [31:0] seq [2];
    logic [31:0] saved;

    reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_read = 1'b0; d_write = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_rsp = 1'b0; mem_rdata = 32'h0;
    mem_mode = 1; mem_delay = 0; mem_fixed = 0; mem_fixed_val = 32'h0;
    m_own = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_addr_chk = 1; m_bc = 0; m_fw = 0;
    m_if_rsp = 0; m_d_rsp = 0; m_err = 0; m_if_rdata = 0; m_d_rdata = 0;
    seq[0] = 32'h0; seq[1] = 32'h0;

    tick(); tick();
    reset = 1'b0;

    // Single fetch, memory answering one cycle after the command.
    if_req = 1'b1; if_addr = 32'h40; mem_mode = 1; mem_delay = 1;
    mem_fixed = 1; mem_fixed_val = 32'h0000_0033;
    first_rd = -1; first_rsp = -1; cnt_a = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (mem_read && first_rd < 0) first_rd = c;
      if (if_rsp && first_rsp < 0) first_rsp = c;
      if (d_rsp) cnt_a++;
      if (m_if_rsp) if_req = 1'b0;
    end
    mem_fixed = 0;
    check_eq("fetch_cmd_cycle", 32'(first_rd), 32'd1);
    check_eq("fetch_rsp_cycle", 32'(first_rsp), 32'd3);
    check_eq("fetch_rdata", if_rdata, 32'h0000_0033);
    check_eq("fetch_no_drsp", 32'(cnt_a), 32'd0);

    // Simultaneous fetch and data read: data first, fetch right after.
    mem_delay = 0; if_req = 1'b1; if_addr = 32'h80; d_read = 1'b1; d_addr = 32'h100;
    n_cmd = 0; prev_cmd = 0; drsp_cyc = -1; cmd2_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if ((mem_read | mem_write) && !prev_cmd) begin
        if (n_cmd < 2) seq[n_cmd] = mem_addr;
        if (n_cmd == 1) cmd2_cyc = c;
        n_cmd++;
      end
      prev_cmd = mem_read | mem_write;
      if (d_rsp && drsp_cyc < 0) drsp_cyc = c;
      if (m_if_rsp) if_req = 1'b0;
      if (m_d_rsp) d_read = 1'b0;
    end
    check_eq("simul_first_addr", seq[0], 32'h100);
    check_eq("simul_second_addr", seq[1], 32'h80);
    check_eq("simul_drsp_cycle", 32'(drsp_cyc), 32'd2);
    check_eq("simul_fetch_cmd_cycle", 32'(cmd2_cyc), 32'd3);

    // Starvation: data requested continuously, zero-wait memory.
    if_req = 1'b1; if_addr = 32'h44; d_read = 1'b1; d_addr = 32'h104; mem_delay = 0;
    cnt_a = 0; got_if = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (d_rsp && !got_if) cnt_a++;
      if (if_rsp) got_if = 1;
      if (m_if_rsp) begin if_req = 1'b0; d_read = 1'b0; end
    end
    check_eq("starve_fetch_served", 32'(got_if), 32'd1);
    check_eq("starve_bound", 32'(cnt_a <= 3), 32'd1);
    check_eq("starve_data_before_fetch", 32'(cnt_a), 32'd2);

    // Write with a 5-cycle memory stall.
    saved = m_d_rdata;
    d_write = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; mem_delay = 5;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (mem_write) cnt_a++;
      if (d_rsp) cnt_b++;
      if (m_d_rsp) d_write = 1'b0;
    end
    check_eq("write_cmd_cycles", 32'(cnt_a), 32'd6);
    check_eq("write_rsp_count", 32'(cnt_b), 32'd1);
    check_eq("write_rdata_kept", d_rdata, saved);

    // Timeout: memory never answers.
    d_read = 1'b1; d_addr = 32'h300; mem_mode = 2;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 25; c++) begin
      tick();
      if (mem_read) cnt_a++;
      if (bus_error) begin
        cnt_b++;
        check_eq("timeout_drsp", 32'(d_rsp), 32'd1);
        check_eq("timeout_rdata", d_rdata, 32'd0);
      end
      if (m_d_rsp) d_read = 1'b0;
    end
    check_eq("timeout_busy_cycles", 32'(cnt_a), 32'd16);
    check_eq("timeout_error_count", 32'(cnt_b), 32'd1);

    // Reset in the middle of a fetch, then a normal fetch.
    if_req = 1'b1; if_addr = 32'h50; mem_mode = 2;
    for (int c = 1; c <= 3; c++) tick();
    reset = 1'b1;
    tick();
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    reset = 1'b0; if_req = 1'b0; cnt_a = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (if_rsp) cnt_a++;
    end
    check_eq("rst_no_if_rsp", 32'(cnt_a), 32'd0);
    if_req = 1'b1; if_addr = 32'h60; mem_mode = 1; mem_delay = 2; cnt_a = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (if_rsp) cnt_a++;
      if (m_if_rsp) if_req = 1'b0;
    end
    check_eq("post_rst_fetch", 32'(cnt_a), 32'd1);

    // Randomized traffic with occasional resets.
    mem_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end
      tick();
      if (!reset) auto_requesters();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
